// File: rtl/status_reg_stack.sv
// Condition-flag register with per-bit write mask and a DEPTH-entry save/restore stack.
// Optional sticky misuse flag (err/err_clr ports) enabled by defining STATUS_REG_ERR_EN.
module status_reg_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [WIDTH-1:0] datain,
  input  logic             push,
  input  logic             pop,
`ifdef STATUS_REG_ERR_EN
  input  logic             err_clr,
  output logic             err,
`endif
  output logic [WIDTH-1:0] dataout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] live_q, live_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic          is_empty, is_full;
  logic          push_do, pop_do, xchg, push_drop, pop_bad;
  logic [IW-1:0] push_idx, top_idx;
  logic [WIDTH-1:0] top_val, merged;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // Push+pop on an empty stack degrades to a plain push.
  assign xchg      = push & pop & ~is_empty;
  assign pop_do    = pop & ~push & ~is_empty;
  assign push_do   = push & (~pop | is_empty) & ~is_full;
  assign push_drop = push & ~pop & is_full;
  assign pop_bad   = pop & ~push & is_empty;

  assign push_idx = IW'(count_q);
  assign top_idx  = IW'(count_q - ONE_C);
  assign top_val  = stack_q[top_idx];
  assign merged   = (live_q & ~wr_mask) | (datain & wr_mask);

  always_comb begin
    live_d  = live_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];

    if (xchg || pop_do) begin
      live_d = top_val;
    end else if (wr_en) begin
      live_d = merged;
    end

    // The stack always captures the live value as it was before this edge.
    if (push_do) begin
      stack_d[push_idx] = live_q;
      count_d = count_q + ONE_C;
    end else if (xchg) begin
      stack_d[top_idx] = live_q;
    end else if (pop_do) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q  <= '0;
      count_q <= '0;
    end else begin
      live_q  <= live_d;
      count_q <= count_d;
    end
  end

  // Stack entries are not reset: they are unreachable while count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
  end

`ifdef STATUS_REG_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = (err_q & ~err_clr) | push_drop | pop_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_misuse;
  assign unused_misuse = push_drop | pop_bad;
`endif

  assign dataout = live_q;
  assign count   = count_q;
  assign empty   = is_empty;
  assign full    = is_full;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed bench for status_reg_stack (WIDTH=4, DEPTH=2); err checks compiled in
// only when STATUS_REG_ERR_EN is defined.
module tb_status_reg_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] datain;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic             err;
  logic [WIDTH-1:0] dataout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  int checks = 0;
  int errors = 0;

  status_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_mask (wr_mask),
    .datain  (datain),
    .push    (push),
    .pop     (pop),
`ifdef STATUS_REG_ERR_EN
    .err_clr (err_clr),
    .err     (err),
`endif
    .dataout (dataout),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

`ifndef STATUS_REG_ERR_EN
  assign err = 1'b0;
`endif

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, sample 1ns after the next rising edge.
  task automatic step(input logic r_n, input logic we, input logic [WIDTH-1:0] m,
                      input logic [WIDTH-1:0] d, input logic pu, input logic po,
                      input logic clr);
    @(negedge clk);
    rst_n = r_n; wr_en = we; wr_mask = m; datain = d; push = pu; pop = po; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] d,
                             input logic [CW-1:0] c);
    check({tag, ".dataout"}, 32'(dataout), 32'(d));
    check({tag, ".count"},   32'(count),   32'(c));
    check({tag, ".empty"},   32'(empty),   32'(c == 0));
    check({tag, ".full"},    32'(full),    32'(c == DEPTH));
  endtask

  task automatic check_err(input string tag, input logic e);
`ifdef STATUS_REG_ERR_EN
    check({tag, ".err"}, 32'(err), 32'(e));
`else
    if (e !== 1'bx && tag.len() < 0) $display("unreachable");
`endif
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_mask = '0; datain = '0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_state("reset", 4'h0, 2'd0);
    check_err("reset", 1'b0);

    // Full and masked writes
    step(1'b1, 1'b1, 4'hF, 4'hA, 1'b0, 1'b0, 1'b0);
    check_state("wr_full", 4'hA, 2'd0);
    step(1'b1, 1'b1, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0);
    check_state("wr_masked", 4'h9, 2'd0);

    // Push saves the pre-write value; pop beats a simultaneous write
    step(1'b1, 1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0);
    check_state("push_wr", 4'h3, 2'd1);
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    check_state("pop_prio", 4'h9, 2'd0);
    check_err("pop_prio", 1'b0);

    // Fill, overflow, clear, drain
    step(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0);
    check_state("push1", 4'h2, 2'd1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_state("push2_full", 4'h2, 2'd2);
    check_err("push2_full", 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'h4, 1'b1, 1'b0, 1'b0);
    check_state("push_overflow", 4'h4, 2'd2);
    check_err("push_overflow", 1'b1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_err("err_clr", 1'b0);
    check_state("err_clr", 4'h4, 2'd2);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_state("pop_a", 4'h2, 2'd1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_state("pop_b", 4'h1, 2'd0);

    // New error in the same cycle as err_clr keeps err set
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    check_state("pop_empty_clr", 4'h1, 2'd0);
    check_err("pop_empty_clr", 1'b1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_err("clr_again", 1'b0);

    // Exchange: count=1, top=7, live=C
    step(1'b1, 1'b1, 4'hF, 4'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0);
    check_state("xchg_setup", 4'hC, 2'd1);
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    check_state("xchg", 4'h7, 2'd1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_state("xchg_pop", 4'hC, 2'd0);

    // Push+pop on empty acts as push with the write honoured
    step(1'b1, 1'b1, 4'hF, 4'h6, 1'b1, 1'b1, 1'b0);
    check_state("pushpop_empty", 4'h6, 2'd1);
    check_err("pushpop_empty", 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_state("pushpop_empty_pop", 4'hC, 2'd0);

    // Pop on empty: live follows write rules, err set
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
    check_state("pop_empty_wr", 4'hD, 2'd0);
    check_err("pop_empty_wr", 1'b1);
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_state("pop_empty", 4'hD, 2'd0);

    // Reset overrides a simultaneous push and write
    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_state("pre_reset_push", 4'hD, 2'd1);
    step(1'b0, 1'b1, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
    check_state("reset_mid", 4'h0, 2'd0);
    check_err("reset_mid", 1'b0);
    idle();
    check_state("post_reset_idle", 4'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
